panda_dmem: RTL and testbench

Memory-side responder for the Panda core's data port. It sits behind the load/store unit, owns a word-organised local data RAM and services one read or write request at a time through a req/gnt/rvalid handshake. Write data arrives already byte-lane aligned with byte enables. Reads always return the full 32-bit word, and the core performs width selection and sign/zero extension. Wait states are configurable so the core's stall logic can be exercised against slow memory.

---
 rtl/panda_dmem_if.sv | 23 ++
 rtl/panda_dmem.sv | 124 ++++++++++++
 tb/tb_panda_dmem.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/panda_dmem_if.sv
// Request/response bus between the Panda load/store unit and its data RAM.
// Signal names follow the core's data-port naming.
interface panda_dmem_if;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/panda_dmem.sv
// Panda data-port responder: word RAM with byte-enable stores,
// req/gnt/rvalid handshake and configurable wait states.
module panda_dmem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    panda_dmem_if.slave  bus
);
    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LIMIT    = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [3:0]     r_cnt;
    logic [3:0]     w_cnt_next;
    logic           r_we;
    logic           r_inr;
    logic [3:0]     r_be;
    logic [31:0]    r_wdata;
    logic [AW-1:0]  r_idx;
    logic [31:0]    r_rdata;
    logic           r_err;
    logic [31:0]    r_mem [DEPTH_WORDS];

    logic [31:0]    w_off;
    logic           w_inr;
    logic [AW-1:0]  w_idx;
    logic           w_gnt;
    logic           w_commit;
    logic           w_c_we;
    logic           w_c_inr;
    logic [3:0]     w_c_be;
    logic [31:0]    w_c_wdata;
    logic [AW-1:0]  w_c_idx;
    logic           w_unused;

    // Unsigned difference: addresses below the base wrap and fall out of range
    assign w_off    = bus.addr_i - BASE_ADDR;
    assign w_inr    = w_off < LIMIT;
    assign w_idx    = w_off[AW+1:2];
    assign w_unused = ^{w_off[1:0], w_off[31:AW+2]};

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_gnt      = 1'b0;
        unique case (r_state)
            S_IDLE, S_RESP: begin
                w_gnt = bus.req_i & rst_ni;
                if (w_gnt) begin
                    if (WAIT_STATES > 0) begin
                        w_next     = S_WAIT;
                        w_cnt_next = CNT_INIT;
                    end else begin
                        w_next = S_RESP;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) w_next = S_RESP;
                else               w_cnt_next = r_cnt - 4'd1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // With no wait states the grant edge is also the commit edge,
    // so the live request fields are used instead of the latched copy.
    assign w_commit  = (w_next == S_RESP);
    assign w_c_we    = w_gnt ? bus.we_i    : r_we;
    assign w_c_inr   = w_gnt ? w_inr       : r_inr;
    assign w_c_be    = w_gnt ? bus.be_i    : r_be;
    assign w_c_wdata = w_gnt ? bus.wdata_i : r_wdata;
    assign w_c_idx   = w_gnt ? w_idx       : r_idx;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_inr   <= 1'b0;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
            r_idx   <= '0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_gnt) begin
                r_we    <= bus.we_i;
                r_inr   <= w_inr;
                r_be    <= bus.be_i;
                r_wdata <= bus.wdata_i;
                r_idx   <= w_idx;
            end
            if (w_commit) begin
                r_err   <= ~w_c_inr;
                r_rdata <= (w_c_inr && !w_c_we) ? r_mem[w_c_idx] : 32'd0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && w_commit && w_c_we && w_c_inr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_c_be[i]) r_mem[w_c_idx][8*i +: 8] <= w_c_wdata[8*i +: 8];
            end
        end
    end

    assign bus.gnt_o    = w_gnt;
    assign bus.rvalid_o = (r_state == S_RESP);
    assign bus.rdata_o  = r_rdata;
    assign bus.err_o    = r_err;
endmodule

// File: tb/tb_panda_dmem.sv
// Directed bench for panda_dmem: three instances with 0, 3 and 2 wait states.
// Inputs driven 1 ns after posedge, outputs sampled on negedge.
module tb_panda_dmem;
    localparam logic [31:0] B0 = 32'h1000_0000;

    logic clk;
    logic r0, r3, r2;
    int   n_cmp = 0;
    int   n_bad = 0;

    panda_dmem_if b0 ();
    panda_dmem_if b3 ();
    panda_dmem_if b2 ();

    panda_dmem #(.DEPTH_WORDS(16), .BASE_ADDR(B0), .WAIT_STATES(0))
        u0 (.clk_i(clk), .rst_ni(r0), .bus(b0.slave));
    panda_dmem #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .WAIT_STATES(3))
        u3 (.clk_i(clk), .rst_ni(r3), .bus(b3.slave));
    panda_dmem #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .WAIT_STATES(2))
        u2 (.clk_i(clk), .rst_ni(r2), .bus(b2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    // {gnt, rvalid, err, rdata}
    function automatic logic [34:0] obs(input int w);
        case (w)
            0:       return {b0.gnt_o, b0.rvalid_o, b0.err_o, b0.rdata_o};
            3:       return {b3.gnt_o, b3.rvalid_o, b3.err_o, b3.rdata_o};
            default: return {b2.gnt_o, b2.rvalid_o, b2.err_o, b2.rdata_o};
        endcase
    endfunction

    task automatic put(input int w, input logic req, input logic we,
                       input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd);
        case (w)
            0: begin
                b0.req_i = req; b0.we_i = we; b0.be_i = be;
                b0.addr_i = addr; b0.wdata_i = wd;
            end
            3: begin
                b3.req_i = req; b3.we_i = we; b3.be_i = be;
                b3.addr_i = addr; b3.wdata_i = wd;
            end
            default: begin
                b2.req_i = req; b2.we_i = we; b2.be_i = be;
                b2.addr_i = addr; b2.wdata_i = wd;
            end
        endcase
    endtask

    // One transaction; lat = cycles from grant to rvalid, -1 on timeout
    task automatic xact(input int w, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd,
                        output logic er);
        logic [34:0] o;
        bit          got;
        lat = -1;
        rd  = 32'hx;
        er  = 1'bx;
        got = 0;
        @(posedge clk); #1;
        put(w, 1'b1, we, be, addr, wd);
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            o = obs(w);
            if (o[34]) got = 1;
        end
        @(posedge clk); #1;
        put(w, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        if (!got) return;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            o = obs(w);
            if (o[33]) begin
                lat = k;
                rd  = o[31:0];
                er  = o[32];
                return;
            end
        end
    endtask

    task automatic test_reset();
        logic [34:0] o0, o3, o2;
        r0 = 0; r3 = 0; r2 = 0;
        put(0, 0, 0, 0, 0, 0);
        put(3, 0, 0, 0, 0, 0);
        put(2, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 1) put(0, 1, 0, 4'hF, B0, 0);
            if (i == 2) begin
                r0 = 1; r3 = 1; r2 = 1;
                put(0, 0, 0, 0, 0, 0);
            end
            @(negedge clk);
            o0 = obs(0); o3 = obs(3); o2 = obs(2);
            n_cmp++;
            if ({o0, o3, o2} !== 105'd0) begin
                n_bad++;
                $display("FAIL reset_%0d: got %h %h %h want all 0", i, o0, o3, o2);
            end
        end
    endtask

    task automatic test_be_merge();
        int lat; logic [31:0] rd; logic er;
        xact(0, 1, 4'hF, B0 + 8, 32'hAABB_CCDD, lat, rd, er);
        n_cmp++;
        if (lat != 1 || {er, rd} !== 33'd0) begin
            n_bad++;
            $display("FAIL be_st1: got lat=%0d err=%b rd=%h want 1 0 0", lat, er, rd);
        end
        xact(0, 1, 4'h8, B0 + 8, 32'h1100_0000, lat, rd, er);
        n_cmp++;
        if (lat != 1 || {er, rd} !== 33'd0) begin
            n_bad++;
            $display("FAIL be_st2: got lat=%0d err=%b rd=%h want 1 0 0", lat, er, rd);
        end
        xact(0, 0, 4'h0, B0 + 8, 32'h0, lat, rd, er);
        n_cmp++;
        if (lat != 1 || {er, rd} !== {1'b0, 32'h11BB_CCDD}) begin
            n_bad++;
            $display("FAIL be_ld: got lat=%0d err=%b rd=%h want 1 0 11bbccdd", lat, er, rd);
        end
        xact(0, 1, 4'h0, B0 + 8, 32'hFFFF_FFFF, lat, rd, er);
        n_cmp++;
        if (lat != 1 || {er, rd} !== 33'd0) begin
            n_bad++;
            $display("FAIL be_zero_st: got lat=%0d err=%b rd=%h want 1 0 0", lat, er, rd);
        end
        xact(0, 0, 4'hF, B0 + 8, 32'h0, lat, rd, er);
        n_cmp++;
        if (rd !== 32'h11BB_CCDD) begin
            n_bad++;
            $display("FAIL be_zero_ld: got %h want 11bbccdd", rd);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic er;
        logic [34:0] o, e;
        logic [31:0] ed;
        for (int i = 0; i < 4; i++)
            xact(0, 1, 4'hF, B0 + 32'(4 * i), 32'(i), lat, rd, er);
        @(posedge clk); #1;
        for (int c = 0; c < 6; c++) begin
            if (c < 4) put(0, 1, 0, 4'hF, B0 + 32'(4 * c), 0);
            else       put(0, 0, 0, 0, 0, 0);
            @(negedge clk);
            o  = obs(0);
            ed = (c == 0) ? 32'd0 : (c >= 5) ? 32'd3 : 32'(c - 1);
            e  = {(c < 4), (c >= 1 && c <= 4), 1'b0, ed};
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL b2b_c%0d: got %h want %h", c, o, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store_load_fwd();
        logic [34:0] o;
        @(posedge clk); #1;
        put(0, 1, 1, 4'hF, B0 + 4, 32'hDEAD_BEEF);
        @(negedge clk);
        o = obs(0);
        n_cmp++;
        if (o !== {2'b10, 1'b0, 32'd3}) begin
            n_bad++;
            $display("FAIL fwd_st: got %h want %h", o, {2'b10, 1'b0, 32'd3});
        end
        @(posedge clk); #1;
        put(0, 1, 0, 4'h0, B0 + 4, 32'h0);
        @(negedge clk);
        o = obs(0);
        n_cmp++;
        if (o !== {2'b11, 1'b0, 32'd0}) begin
            n_bad++;
            $display("FAIL fwd_st_resp: got %h want %h", o, {2'b11, 1'b0, 32'd0});
        end
        @(posedge clk); #1;
        put(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        o = obs(0);
        n_cmp++;
        if (o !== {2'b01, 1'b0, 32'hDEAD_BEEF}) begin
            n_bad++;
            $display("FAIL fwd_ld: got %h want %h", o, {2'b01, 1'b0, 32'hDEAD_BEEF});
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic er;
        xact(0, 1, 4'hF, B0 + 64, 32'h5555_5555, lat, rd, er);
        n_cmp++;
        if (lat != 1 || {er, rd} !== {1'b1, 32'd0}) begin
            n_bad++;
            $display("FAIL oor_st: got lat=%0d err=%b rd=%h want 1 1 0", lat, er, rd);
        end
        xact(0, 0, 4'hF, B0, 32'h0, lat, rd, er);
        n_cmp++;
        if ({er, rd} !== 33'd0) begin
            n_bad++;
            $display("FAIL oor_ram: got err=%b rd=%h want 0 0", er, rd);
        end
        xact(0, 0, 4'hF, B0 - 4, 32'h0, lat, rd, er);
        n_cmp++;
        if (lat != 1 || {er, rd} !== {1'b1, 32'd0}) begin
            n_bad++;
            $display("FAIL oor_ld: got lat=%0d err=%b rd=%h want 1 1 0", lat, er, rd);
        end
        xact(0, 0, 4'hF, B0 + 4, 32'h0, lat, rd, er);
        n_cmp++;
        if ({er, rd} !== {1'b0, 32'hDEAD_BEEF}) begin
            n_bad++;
            $display("FAIL oor_clear: got err=%b rd=%h want 0 deadbeef", er, rd);
        end
    endtask

    task automatic test_wait_states();
        int lat; logic [31:0] rd; logic er;
        logic [34:0] o;
        bit got;
        xact(3, 1, 4'hF, 32'd8, 32'hCAFE_F00D, lat, rd, er);
        n_cmp++;
        if (lat != 4 || er !== 1'b0) begin
            n_bad++;
            $display("FAIL ws_st_lat: got lat=%0d err=%b want 4 0", lat, er);
        end
        @(posedge clk); #1;
        put(3, 1, 0, 4'hF, 32'd8, 0);
        @(negedge clk);
        o = obs(3);
        n_cmp++;
        if (o[34:33] !== 2'b10) begin
            n_bad++;
            $display("FAIL ws_gnt: got %b want 10", o[34:33]);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            o = obs(3);
            n_cmp++;
            if (o[34:33] !== 2'b00) begin
                n_bad++;
                $display("FAIL ws_wait%0d: got %b want 00", k, o[34:33]);
            end
        end
        @(negedge clk);
        o = obs(3);
        n_cmp++;
        if (o !== {2'b11, 1'b0, 32'hCAFE_F00D}) begin
            n_bad++;
            $display("FAIL ws_resp: got %h want %h", o, {2'b11, 1'b0, 32'hCAFE_F00D});
        end
        @(posedge clk); #1;
        put(3, 0, 0, 0, 0, 0);
        got = 0;
        lat = -1;
        for (int k = 1; k <= 10 && !got; k++) begin
            @(negedge clk);
            o = obs(3);
            if (o[33]) begin
                got = 1;
                lat = k;
            end
        end
        n_cmp++;
        if (lat != 4 || o[31:0] !== 32'hCAFE_F00D) begin
            n_bad++;
            $display("FAIL ws_second: got lat=%0d rd=%h want 4 cafef00d", lat, o[31:0]);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic er;
        logic [34:0] o;
        bit seen;
        xact(2, 1, 4'hF, 32'd20, 32'h0, lat, rd, er);
        n_cmp++;
        if (lat != 3) begin
            n_bad++;
            $display("FAIL rm_pre: got lat=%0d want 3", lat);
        end
        @(posedge clk); #1;
        put(2, 1, 1, 4'hF, 32'd20, 32'hFFFF_FFFF);
        @(negedge clk);
        o = obs(2);
        n_cmp++;
        if (o[34] !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_gnt: got %b want 1", o[34]);
        end
        @(posedge clk); #1;
        r2 = 0;
        put(2, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        r2 = 1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            o = obs(2);
            if (o[33]) seen = 1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_norv: got rvalid=%b want 0", seen);
        end
        xact(2, 0, 4'hF, 32'd20, 32'h0, lat, rd, er);
        n_cmp++;
        if (lat != 3 || {er, rd} !== 33'd0) begin
            n_bad++;
            $display("FAIL rm_ld: got lat=%0d err=%b rd=%h want 3 0 0", lat, er, rd);
        end
    endtask

    initial begin
        test_reset();
        test_be_merge();
        test_back_to_back();
        test_store_load_fwd();
        test_out_of_range();
        test_wait_states();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
